// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one input bit per clock.
// start/busy/done handshake; result and overflow flag held until the next done.
module bin2bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    shift_q, shift_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic [4*DIGITS-1:0] bcd_out_q, bcd_out_d;
  logic                overflow_q, overflow_d;

  logic [4*DIGITS-1:0] adj;
  logic [4*DIGITS-1:0] bcd_nxt;
  logic                ovf_nxt;

  // Add-3 is per digit with no inter-digit carry; a digit never exceeds 9+3=12.
  always_comb begin
    adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                 : bcd_q[4*i +: 4];
    end
    bcd_nxt = {adj[4*DIGITS-2:0], shift_q[WIDTH-1]};
    ovf_nxt = ovf_q | adj[4*DIGITS-1];
  end

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    bcd_out_d  = bcd_out_q;
    overflow_d = overflow_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          shift_d = bin_in;
          bcd_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        shift_d = shift_q << 1;
        bcd_d   = bcd_nxt;
        ovf_d   = ovf_nxt;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          bcd_out_d  = bcd_nxt;
          overflow_d = ovf_nxt;
          state_d    = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      bcd_out_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      bcd_out_q  <= bcd_out_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = (state_q == SHIFT);
  assign done     = (state_q == DONE);
  assign bcd_out  = bcd_out_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: a 3-digit and a 2-digit instance, table-driven
// single conversions plus hand-written sequences for the handshake corner cases.
module tb_bin2bcd_seq;

  logic        clk;
  logic        rst_n;
  logic        start_r;
  logic [7:0]  bin_r;
  logic        sel;

  logic        start3, busy3, done3, ovf3;
  logic [11:0] bcd3;
  logic        start2, busy2, done2, ovf2;
  logic [7:0]  bcd2;

  logic        busy_s, done_s, ovf_s;
  logic [11:0] bcd_s;

  int tests;
  int fails;

  assign start3 = start_r & ~sel;
  assign start2 = start_r & sel;
  assign busy_s = sel ? busy2 : busy3;
  assign done_s = sel ? done2 : done3;
  assign ovf_s  = sel ? ovf2 : ovf3;
  assign bcd_s  = sel ? {4'h0, bcd2} : bcd3;

  bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .bin_in(bin_r),
    .busy(busy3), .done(done3), .bcd_out(bcd3), .overflow(ovf3)
  );

  bin2bcd_seq #(.WIDTH(8), .DIGITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .bin_in(bin_r),
    .busy(busy2), .done(done2), .bcd_out(bcd2), .overflow(ovf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        s;
    logic [7:0]  bin;
    logic [11:0] bcd;
    logic        ovf;
  } vec_t;

  vec_t vecs[8];

  // One conversion with cycle-exact busy/done checks; inputs change at negedge.
  task automatic run_conv(input logic s, input logic [7:0] v,
                          input logic [11:0] exp_bcd, input logic exp_ovf);
    @(negedge clk);
    sel = s; start_r = 1'b1; bin_r = v;
    @(posedge clk);
    #1 start_r = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      check($sformatf("busy_c%0d_v%0d", n, v), busy_s, 1);
      check($sformatf("nodone_c%0d_v%0d", n, v), done_s, 0);
    end
    @(negedge clk);
    check($sformatf("done_v%0d", v), done_s, 1);
    check($sformatf("busy_at_done_v%0d", v), busy_s, 0);
    check($sformatf("bcd_v%0d", v), bcd_s, exp_bcd);
    check($sformatf("ovf_v%0d", v), ovf_s, exp_ovf);
    @(negedge clk);
    check($sformatf("done_one_cycle_v%0d", v), done_s, 0);
    check($sformatf("bcd_hold_v%0d", v), bcd_s, exp_bcd);
  endtask

  initial begin
    int done_cnt;
    int pos1, pos2;

    tests = 0; fails = 0;
    sel = 1'b0; start_r = 1'b0; bin_r = '0;

    vecs[0] = '{1'b0, 8'd0,   12'h000, 1'b0};
    vecs[1] = '{1'b0, 8'd255, 12'h255, 1'b0};
    vecs[2] = '{1'b0, 8'd99,  12'h099, 1'b0};
    vecs[3] = '{1'b0, 8'd128, 12'h128, 1'b0};
    vecs[4] = '{1'b1, 8'd200, 12'h000, 1'b1};
    vecs[5] = '{1'b1, 8'd99,  12'h099, 1'b0};
    vecs[6] = '{1'b1, 8'd150, 12'h050, 1'b1};
    vecs[7] = '{1'b0, 8'd7,   12'h007, 1'b0};

    // Reset state
    rst_n = 1'b0;
    #12;
    check("rst_busy3", busy3, 0);
    check("rst_done3", done3, 0);
    check("rst_bcd3",  bcd3, 0);
    check("rst_ovf3",  ovf3, 0);
    check("rst_bcd2",  bcd2, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_conv(vecs[i].s, vecs[i].bin, vecs[i].bcd, vecs[i].ovf);

    // Start and bin_in changes during SHIFT are ignored.
    @(negedge clk);
    sel = 1'b0; start_r = 1'b1; bin_r = 8'd37;
    @(posedge clk);
    #1 start_r = 1'b0;
    done_cnt = 0;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      if (n == 3) begin start_r = 1'b1; bin_r = 8'd200; end
      if (n == 6) start_r = 1'b0;
      if (done_s) begin
        done_cnt++;
        check("ignore_start_pos", n, 9);
        check("ignore_start_bcd", bcd_s, 12'h037);
      end
    end
    check("ignore_start_done_cnt", done_cnt, 1);

    // Back-to-back conversions with start held high.
    @(negedge clk);
    sel = 1'b0; start_r = 1'b1; bin_r = 8'd10;
    @(posedge clk);
    pos1 = -1; pos2 = -1;
    for (int n = 1; n <= 22; n++) begin
      @(negedge clk);
      if (n == 1) bin_r = 8'd250;
      if (n == 10) start_r = 1'b0;
      if (n == 12) check("b2b_hold_bcd", bcd_s, 12'h010);
      if (n == 12) check("b2b_busy", busy_s, 1);
      if (done_s) begin
        if (pos1 < 0) begin
          pos1 = n;
          check("b2b_first_bcd", bcd_s, 12'h010);
        end else begin
          pos2 = n;
          check("b2b_second_bcd", bcd_s, 12'h250);
        end
      end
    end
    check("b2b_first_pos", pos1, 9);
    check("b2b_spacing", pos2 - pos1, 9);

    // Reset in the middle of a conversion of 255.
    @(negedge clk);
    sel = 1'b0; start_r = 1'b1; bin_r = 8'd255;
    @(posedge clk);
    #1 start_r = 1'b0;
    for (int n = 1; n <= 5; n++) @(negedge clk);
    check("midrst_busy_before", busy_s, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy_s, 0);
    check("midrst_bcd", bcd_s, 0);
    check("midrst_done", done_s, 0);
    done_cnt = 0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (done_s) done_cnt++;
    end
    rst_n = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (done_s) done_cnt++;
    end
    check("midrst_no_done", done_cnt, 0);
    check("midrst_bcd_after", bcd_s, 0);
    run_conv(1'b0, 8'd42, 12'h042, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
